// File: rtl/crypto_host_sequencer_if.sv
// ----------------------------------------------------------------------------
// crypto_host_sequencer_if
// Bundles the host request/response handshakes and the crypto core control
// and result signals seen by crypto_host_sequencer.
//
// Modports:
//   master : the sequencer; drives req_ready, rsp_*, busy and core_* controls,
//            and observes the host request and the core output bus/strobes.
//   slave  : the host/core side; the mirror image of master.
//
// Signals:
//   req_valid/req_ready/req_mode/req_data/req_key : request handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_key/rsp_err  : response handshake
//   busy                                          : operation in flight
//   core_bgn/core_mode/core_data/core_key/core_rst_n : core controls
//   core_bus/core_out_key/core_delay_key/core_fin    : core results/strobes
// ----------------------------------------------------------------------------
interface crypto_host_sequencer_if #(
    parameter int DATA_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic              req_mode;
    logic [DATA_W-1:0] req_data;
    logic [DATA_W-1:0] req_key;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] rsp_key;
    logic              rsp_err;
    logic              busy;

    logic              core_bgn;
    logic [1:0]        core_mode;
    logic [DATA_W-1:0] core_data;
    logic [DATA_W-1:0] core_key;
    logic              core_rst_n;
    logic [DATA_W-1:0] core_bus;
    logic              core_out_key;
    logic              core_delay_key;
    logic              core_fin;

    modport master (
        input  req_valid, req_mode, req_data, req_key, rsp_ready,
               core_bus, core_out_key, core_delay_key, core_fin,
        output req_ready, rsp_valid, rsp_data, rsp_key, rsp_err, busy,
               core_bgn, core_mode, core_data, core_key, core_rst_n
    );

    modport slave (
        output req_valid, req_mode, req_data, req_key, rsp_ready,
               core_bus, core_out_key, core_delay_key, core_fin,
        input  req_ready, rsp_valid, rsp_data, rsp_key, rsp_err, busy,
               core_bgn, core_mode, core_data, core_key, core_rst_n
    );
endinterface

// File: rtl/crypto_host_sequencer.sv
// ----------------------------------------------------------------------------
// crypto_host_sequencer
// Host-side initiator for the crypto core control unit. Accepts one
// encrypt/decrypt request, holds data/key/mode stable on the core inputs,
// pulses core_bgn, captures result data and key from the shared core output
// bus using the core strobes, and returns them over a response handshake.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   bus  : crypto_host_sequencer_if.master (request, response, core signals)
//
// Parameters:
//   DATA_W         : width of data block, key and core output bus
//   TIMEOUT_CYCLES : WAIT-cycle limit before the core is aborted
//
// Optional feature (macro CRYPTO_SEQ_TIMEOUT_EN):
//   When defined, a WAIT-cycle counter aborts a stuck operation: the core is
//   held in reset for two cycles and an error response with zeroed data/key
//   is returned. When undefined, WAIT waits indefinitely, core_rst_n is
//   constant 1 and rsp_err is constant 0.
// ----------------------------------------------------------------------------
module crypto_host_sequencer #(
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    crypto_host_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
    localparam logic [2:0] S_ABORT  = 3'd4;
`endif

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_ENC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;

    // A zero limit would make the abort path meaningless.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]        r_state;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_busy;
    logic              r_core_bgn;
    logic [1:0]        r_core_mode;
    logic [DATA_W-1:0] r_core_data;
    logic [DATA_W-1:0] r_core_key;
    logic [DATA_W-1:0] r_rsp_data;
    logic [DATA_W-1:0] r_rsp_key;

`ifdef CRYPTO_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // r_cnt holds the number of WAIT cycles already completed, so the limit
    // is hit on the WAIT cycle where r_cnt equals TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_abort_cnt;
    logic              r_rsp_err;
    logic              r_core_rst_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_core_bgn  <= 1'b0;
            r_core_mode <= MODE_IDLE;
            r_core_data <= '0;
            r_core_key  <= '0;
            r_rsp_data  <= '0;
            r_rsp_key   <= '0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
            r_cnt        <= '0;
            r_abort_cnt  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_core_rst_n <= 1'b1;
`endif
        end else begin
            // core_bgn is a single-cycle pulse; only the accept branch raises it.
            r_core_bgn <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_core_data <= bus.req_data;
                        r_core_key  <= bus.req_key;
                        r_core_mode <= bus.req_mode ? MODE_ENC : MODE_DEC;
                        r_rsp_data  <= '0;
                        r_rsp_key   <= '0;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_core_bgn  <= 1'b1;
                        r_state     <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
`ifdef CRYPTO_SEQ_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // Strobes are captured even in the fin cycle; a repeated
                    // strobe simply overwrites the earlier capture.
                    if (bus.core_out_key) begin
                        r_rsp_data <= bus.core_bus;
                    end
                    if (bus.core_delay_key) begin
                        r_rsp_key <= bus.core_bus;
                    end

                    if (bus.core_fin) begin
                        r_rsp_valid <= 1'b1;
                        r_core_mode <= MODE_IDLE;
                        r_state     <= S_RESP;
                    end
`ifdef CRYPTO_SEQ_TIMEOUT_EN
                    else if (r_cnt == CNT_LAST) begin
                        r_core_rst_n <= 1'b0;
                        r_core_mode  <= MODE_IDLE;
                        r_abort_cnt  <= 1'b0;
                        r_state      <= S_ABORT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end

`ifdef CRYPTO_SEQ_TIMEOUT_EN
                S_ABORT: begin
                    // Core reset spans the two ABORT cycles.
                    if (r_abort_cnt) begin
                        r_core_rst_n <= 1'b1;
                        r_rsp_data   <= '0;
                        r_rsp_key    <= '0;
                        r_rsp_err    <= 1'b1;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_abort_cnt <= 1'b1;
                    end
                end
`endif

                S_RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_key   = r_rsp_key;
    assign bus.busy      = r_busy;
    assign bus.core_bgn  = r_core_bgn;
    assign bus.core_mode = r_core_mode;
    assign bus.core_data = r_core_data;
    assign bus.core_key  = r_core_key;
`ifdef CRYPTO_SEQ_TIMEOUT_EN
    assign bus.rsp_err    = r_rsp_err;
    assign bus.core_rst_n = r_core_rst_n;
`else
    assign bus.rsp_err    = 1'b0;
    assign bus.core_rst_n = 1'b1;
`endif

endmodule
